ps2_kbd_ctrl: RTL

//  Synthesizable PS/2 keyboard receive controller: oversamples ps2_clk/ps2_data on clk, frames
//  11-bit packets, checks start/odd-parity/stop, then sequences E0/F0 prefix bytes into single key

---
 rtl/ps2_kbd_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard receiver with frame checking, E0/F0 prefix decoding and an event FIFO
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, E0, F0, E0F0} st_t;
  logic [SYNC_STAGES-1:0] sc, sd;
  logic [10:0] sr;
  logic [3:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic byte_vld, fall, frame_ok, push, pop, full, wr;
  logic [7:0] byte_q;
  st_t st, st_n;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp, head;
  logic [AW:0] cnt;
  assign fall = sc[SYNC_STAGES-1] & ~sc[SYNC_STAGES-2];
  assign frame_ok = ~sr[0] & (^sr[9:1]) & sr[10];
  // Synchronize the PS/2 pins; idle bus reads as all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= '1;
      sd <= '1;
    end else begin
      sc <= {sc[SYNC_STAGES-2:0], ps2_clk};
      sd <= {sd[SYNC_STAGES-2:0], ps2_data};
    end
  end
  // Shift in bits on PS/2 clock falls, check completed frames, drop stalled partial frames
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      bit_cnt <= '0;
      to_cnt <= '0;
      byte_vld <= 1'b0;
      byte_q <= '0;
      frame_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      byte_vld <= 1'b0;
      frame_err <= 1'b0;
      if (bit_cnt == 4'd11) begin
        bit_cnt <= '0;
        to_cnt <= '0;
        if (frame_ok) begin
          byte_vld <= 1'b1;
          byte_q <= sr[8:1];
        end else begin
          frame_err <= 1'b1;
          err_cnt <= (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;
        end
      end else if (fall) begin
        sr <= {sd[SYNC_STAGES-1], sr[10:1]};
        bit_cnt <= bit_cnt + 4'd1;
        to_cnt <= '0;
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          bit_cnt <= '0;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end
  // Prefix decoder state register
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else st <= st_n;
  end
  // Prefix decoder: E0/F0 accumulate into the state, any other byte emits an event
  always_comb begin
    st_n = st;
    push = 1'b0;
    if (byte_vld) begin
      if (byte_q == 8'hE0) st_n = (st == F0 || st == E0F0) ? E0F0 : E0;
      else if (byte_q == 8'hF0) st_n = (st == E0 || st == E0F0) ? E0F0 : F0;
      else begin
        push = 1'b1;
        st_n = IDLE;
      end
    end
  end
  assign evt_valid = cnt != '0;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop = evt_valid & evt_ready;
  assign wr = push & (~full | pop);
  assign head = evt_valid ? rp : rp - AW'(1);
  assign {evt_ext, evt_brk, evt_code} = mem[head];
  // Event FIFO; when empty the outputs keep showing the most recently popped entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= {st == E0 || st == E0F0, st == F0 || st == E0F0, byte_q};
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      if (push & ~wr) overflow <= 1'b1;
    end
  end
endmodule
